sha256_msg_padder: RTL and testbench

//  Upstream stage of the SHA-256 compression engine.
//  - Reads a NUM_OF_WORDS-word message from word-addressed memory.
//  - Applies standard SHA-256 padding and streams each 512-bit block as 16 x 32-bit words.
//  - Output is a valid/ready interface into the compression core.
//  - Replaces in-core message buffering; no 512-bit register is held here.

---
 rtl/sha256_pkg.sv | 17 +
 rtl/sha256_msg_padder.sv | 92 +++++++++
 tb/tb_sha256_msg_padder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: constants, state encoding and padding helpers shared by the SHA-256 message padder and compression core
package sha256_pkg;
  localparam int BLOCK_WORDS = 16;
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, GEN, EMIT} pad_state_t;
  function automatic int num_blocks(int n);
    return (n + 2) / BLOCK_WORDS + 1;
  endfunction
  // Non-message word g of an n-word message spread over nb blocks: 1-bit marker, zero fill, or 64-bit bit length.
  function automatic logic [31:0] pad_word(int g, int n, int nb);
    logic [63:0] len;
    len = 64'(n) * 64'd32;
    return g == n ? PAD_WORD :
           g == BLOCK_WORDS * nb - 2 ? len[63:32] :
           g == BLOCK_WORDS * nb - 1 ? len[31:0] : 32'h0;
  endfunction
endpackage

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: reads a NUM_OF_WORDS-word message from memory and streams it SHA-256 padded as 16-word blocks
//   clk/reset_n                  clock, asynchronous active-low reset
//   start/message_addr/done      job request, message base word address, idle flag
//   mem_clk/mem_we/mem_addr/mem_read_data  synchronous-read memory port
//   blk_valid/blk_ready/blk_word/blk_idx/blk_first/blk_last  padded word stream to the compression core
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [31:0] blk_word,
  output logic [3:0]  blk_idx,
  output logic        blk_first,
  output logic        blk_last
);
  localparam int NB = num_blocks(NUM_OF_WORDS);
  localparam logic [15:0] N_W = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LAST_G = 16'(BLOCK_WORDS * NB - 1);
  localparam logic [15:0] LAST_BLK_G = 16'(BLOCK_WORDS * (NB - 1));
  pad_state_t  state_q, state_d;
  logic [15:0] g_q, g_d;
  logic [15:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] word_q, word_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    word_d  = word_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = message_addr;
        g_d     = '0;
        state_d = NUM_OF_WORDS > 0 ? FETCH : GEN;
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        word_d  = mem_read_data;
        valid_d = 1'b1;
        state_d = EMIT;
      end
      GEN: begin
        word_d  = pad_word(int'(g_q), NUM_OF_WORDS, NB);
        valid_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: if (blk_ready) begin
        valid_d = 1'b0;
        g_d     = g_q + 16'd1;
        state_d = g_q == LAST_G ? IDLE : (g_q + 16'd1 < N_W ? FETCH : GEN);
      end
      default: state_d = IDLE;
    endcase
  end
  assign done      = state_q == IDLE;
  assign mem_clk   = clk;
  assign mem_we    = 1'b0;
  assign mem_addr  = addr_q + g_q;
  assign blk_valid = valid_q;
  assign blk_word  = word_q;
  assign blk_idx   = g_q[3:0];
  // Flags are qualified by valid so they read 0 out of reset and between words.
  assign blk_first = valid_q & (g_q < 16'(BLOCK_WORDS));
  assign blk_last  = valid_q & (g_q >= LAST_BLK_G);
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: scoreboard bench for three padder instances (N=20, 13, 14) sharing one memory model
module tb_sha256_msg_padder;
  localparam int NS [3] = '{20, 13, 14};
  logic        clk = 1'b0;
  logic        reset_n;
  logic        blk_ready;
  logic [15:0] message_addr;
  logic        start_a     [3];
  logic        done_a      [3];
  logic        mem_clk_a   [3];
  logic        mem_we_a    [3];
  logic [15:0] mem_addr_a  [3];
  logic [31:0] rd_a        [3];
  logic        blk_valid_a [3];
  logic [31:0] blk_word_a  [3];
  logic [3:0]  blk_idx_a   [3];
  logic        blk_first_a [3];
  logic        blk_last_a  [3];
  logic [31:0] mem [65536];
  typedef struct {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        f;
    logic        l;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    sha256_msg_padder #(.NUM_OF_WORDS(NS[k])) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start_a[k]),
      .message_addr(message_addr),
      .done(done_a[k]),
      .mem_clk(mem_clk_a[k]),
      .mem_we(mem_we_a[k]),
      .mem_addr(mem_addr_a[k]),
      .mem_read_data(rd_a[k]),
      .blk_valid(blk_valid_a[k]),
      .blk_ready(blk_ready),
      .blk_word(blk_word_a[k]),
      .blk_idx(blk_idx_a[k]),
      .blk_first(blk_first_a[k]),
      .blk_last(blk_last_a[k])
    );
    always_ff @(posedge clk) rd_a[k] <= mem[mem_addr_a[k]];
  end
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_run(int n, logic [15:0] a);
    int nb;
    logic [63:0] len;
    exp_t e;
    nb = (n + 2) / 16 + 1;
    len = 64'(n) * 64'd32;
    for (int g = 0; g < 16 * nb; g++) begin
      if (g < n) e.w = 32'(16'(a + 16'(g))) + 32'd1;
      else if (g == n) e.w = 32'h8000_0000;
      else if (g == 16 * nb - 1) e.w = len[31:0];
      else if (g == 16 * nb - 2) e.w = len[63:32];
      else e.w = 32'h0;
      e.idx = 4'(g % 16);
      e.f = g < 16;
      e.l = g >= 16 * (nb - 1);
      q.push_back(e);
    end
  endtask
  task automatic run(int s, logic [15:0] a, bit slow, int abort_at, int restart_at);
    exp_t e;
    int cnt, last_xfer, nb;
    bit held;
    logic [31:0] hold_w;
    nb = (NS[s] + 2) / 16 + 1;
    push_run(NS[s], a);
    cnt = 0;
    last_xfer = -100;
    held = 0;
    hold_w = '0;
    @(negedge clk);
    message_addr = a;
    start_a[s] = 1'b1;
    @(negedge clk);
    start_a[s] = 1'b0;
    check($sformatf("done_fall_n%0d", NS[s]), 64'(done_a[s]), 64'd0);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      blk_ready = slow ? (c % 3 == 2) : 1'b1;
      if (cnt == abort_at) blk_ready = 1'b0;
      start_a[s] = (c == restart_at);
      message_addr = (c == restart_at) ? 16'h1234 : a;
      #1;
      if (done_a[s]) begin
        check("done_rise_latency", 64'(c - last_xfer), 64'd1);
        check("queue_drained", 64'(q.size()), 64'd0);
        check("word_count", 64'(cnt), 64'(16 * nb));
        return;
      end
      if (cnt == abort_at && blk_valid_a[s]) begin
        check("abort_idx", 64'(blk_idx_a[s]), 64'(cnt % 16));
        reset_n = 1'b0;
        #1;
        check("abort_valid", 64'(blk_valid_a[s]), 64'd0);
        check("abort_done", 64'(done_a[s]), 64'd1);
        check("abort_idx0", 64'(blk_idx_a[s]), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        return;
      end
      if (held && blk_valid_a[s]) check("stable_word", 64'(blk_word_a[s]), 64'(hold_w));
      held = blk_valid_a[s] && !blk_ready;
      hold_w = blk_word_a[s];
      if (blk_valid_a[s] && blk_ready) begin
        if (q.size() == 0) check("unexpected_word", 64'(q.size()), 64'd1);
        else begin
          e = q.pop_front();
          check($sformatf("n%0d_w%0d_word", NS[s], cnt), 64'(blk_word_a[s]), 64'(e.w));
          check($sformatf("n%0d_w%0d_idx", NS[s], cnt), 64'(blk_idx_a[s]), 64'(e.idx));
          check($sformatf("n%0d_w%0d_first", NS[s], cnt), 64'(blk_first_a[s]), 64'(e.f));
          check($sformatf("n%0d_w%0d_last", NS[s], cnt), 64'(blk_last_a[s]), 64'(e.l));
        end
        cnt++;
        last_xfer = c;
      end
    end
    check("timeout_done", 64'(done_a[s]), 64'd1);
    q.delete();
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i) + 32'd1;
    reset_n = 1'b0;
    blk_ready = 1'b0;
    message_addr = '0;
    for (int k = 0; k < 3; k++) start_a[k] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(blk_valid_a[0]), 64'd0);
    check("rst_word", 64'(blk_word_a[0]), 64'd0);
    check("rst_idx", 64'(blk_idx_a[0]), 64'd0);
    check("rst_first", 64'(blk_first_a[0]), 64'd0);
    check("rst_last", 64'(blk_last_a[0]), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_a[0]), 64'd0);
    check("rst_done", 64'(done_a[0]), 64'd1);
    check("mem_we", 64'(mem_we_a[0]), 64'd0);
    reset_n = 1'b1;
    run(0, 16'h0000, 1'b0, -1, -1);
    run(0, 16'h0000, 1'b1, -1, -1);
    run(1, 16'h0000, 1'b0, -1, -1);
    run(2, 16'h0000, 1'b0, -1, -1);
    run(0, 16'hFFFE, 1'b0, -1, 40);
    run(0, 16'h0000, 1'b0, 7, -1);
    run(0, 16'h0000, 1'b0, -1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
